// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the RV32I core: stall/flush/redirect of IF, IF_ID and ID_EX,
// plus trap entry (mepc/mcause strobe) for decode exceptions, interrupts and WFI wake-up.
module pipeline_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] IRQ_CODE = 32'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] instruction_addr_id,
    input  logic [4:0]  reg1_raddr,
    input  logic [4:0]  reg2_raddr,
    input  logic        exception_raise_id,
    input  logic [3:0]  exception_code_id,
    input  logic        reg_wen_ex,
    input  logic [4:0]  rd_ex,
    input  logic        ram_load_access_ex,
    input  logic        jump_en_ex,
    input  logic [31:0] jump_addr_ex,
    input  logic        mret_ex,
    input  logic        wfi_ex,
    input  logic [31:0] instruction_addr_ex,
    input  logic        mem_busy,
    input  logic        irq_pending,
    input  logic        mstatus_mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        stall_if,
    output logic        flush_if,
    output logic        flush_id,
    output logic        pc_redirect_en,
    output logic [31:0] pc_redirect_addr,
    output logic        trap_en,
    output logic [31:0] trap_mepc,
    output logic [31:0] trap_mcause
);

    typedef enum logic [1:0] {
        RUN,
        TRAP_DRAIN,
        TRAP_ENTER,
        WFI_SLEEP
    } state_t;

    state_t      state, state_next;
    logic [31:0] pending_pc, pending_pc_next;
    logic [31:0] pending_cause, pending_cause_next;
    logic [31:0] irq_cause;
    logic        load_use;
    logic        irq_take;
    logic        unused_bits;

    assign irq_cause   = {1'b1, 27'b0, IRQ_CODE[3:0]};
    assign irq_take    = irq_pending & mstatus_mie;
    assign unused_bits = ^mtvec[1:0];

    // rs2 is compared even when the instruction has no rs2; a false match just costs a stall.
    assign load_use = ram_load_access_ex & reg_wen_ex & (rd_ex != 5'd0) &
                      ((rd_ex == reg1_raddr) | (rd_ex == reg2_raddr));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pending_pc    <= '0;
            pending_cause <= '0;
        end else begin
            state         <= state_next;
            pending_pc    <= pending_pc_next;
            pending_cause <= pending_cause_next;
        end
    end

    always_comb begin
        state_next         = state;
        pending_pc_next    = pending_pc;
        pending_cause_next = pending_cause;
        stall_if           = 1'b0;
        flush_if           = 1'b0;
        flush_id           = 1'b0;
        pc_redirect_en     = 1'b0;
        pc_redirect_addr   = '0;
        trap_en            = 1'b0;
        trap_mepc          = '0;
        trap_mcause        = '0;

        if (rst) begin
            state_next       = RUN;
            pc_redirect_en   = 1'b1;
            pc_redirect_addr = RESET_PC;
        end else begin
            unique case (state)
                RUN: begin
                    if (jump_en_ex) begin
                        pc_redirect_en   = 1'b1;
                        pc_redirect_addr = jump_addr_ex;
                        flush_if         = 1'b1;
                        flush_id         = 1'b1;
                    end else if (mret_ex) begin
                        pc_redirect_en   = 1'b1;
                        pc_redirect_addr = mepc;
                        flush_if         = 1'b1;
                        flush_id         = 1'b1;
                    end else if (wfi_ex) begin
                        stall_if        = 1'b1;
                        flush_id        = 1'b1;
                        pending_pc_next = instruction_addr_ex + 32'd4;
                        state_next      = WFI_SLEEP;
                    end else if (id_valid & exception_raise_id) begin
                        stall_if           = 1'b1;
                        flush_id           = 1'b1;
                        pending_pc_next    = instruction_addr_id;
                        pending_cause_next = {28'b0, exception_code_id};
                        state_next         = TRAP_DRAIN;
                    end else if (id_valid & irq_take) begin
                        stall_if           = 1'b1;
                        flush_id           = 1'b1;
                        pending_pc_next    = instruction_addr_id;
                        pending_cause_next = irq_cause;
                        state_next         = TRAP_DRAIN;
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        flush_id = 1'b1;
                    end
                end

                TRAP_DRAIN: begin
                    stall_if = 1'b1;
                    flush_id = 1'b1;
                    if (!mem_busy) begin
                        state_next = TRAP_ENTER;
                    end
                end

                TRAP_ENTER: begin
                    trap_en          = 1'b1;
                    trap_mepc        = pending_pc;
                    trap_mcause      = pending_cause;
                    pc_redirect_en   = 1'b1;
                    pc_redirect_addr = {mtvec[31:2], 2'b00};
                    flush_if         = 1'b1;
                    flush_id         = 1'b1;
                    state_next       = RUN;
                end

                WFI_SLEEP: begin
                    stall_if = 1'b1;
                    flush_id = 1'b1;
                    // pending_pc already points past the WFI, so both wake paths resume there.
                    if (irq_take) begin
                        pending_cause_next = irq_cause;
                        state_next         = TRAP_DRAIN;
                    end else if (irq_pending) begin
                        pc_redirect_en   = 1'b1;
                        pc_redirect_addr = pending_pc;
                        flush_if         = 1'b1;
                        state_next       = RUN;
                    end
                end

                default: state_next = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with constant expectations, then a
// randomized run compared against a trap/sleep reference model.
module tb_pipeline_ctrl;

    localparam logic [31:0] RST_PC  = 32'h0000_1000;
    localparam logic [31:0] IRQ_MC  = 32'h8000_000B;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] instruction_addr_id;
    logic [4:0]  reg1_raddr, reg2_raddr;
    logic        exception_raise_id;
    logic [3:0]  exception_code_id;
    logic        reg_wen_ex;
    logic [4:0]  rd_ex;
    logic        ram_load_access_ex;
    logic        jump_en_ex;
    logic [31:0] jump_addr_ex;
    logic        mret_ex, wfi_ex;
    logic [31:0] instruction_addr_ex;
    logic        mem_busy, irq_pending, mstatus_mie;
    logic [31:0] mtvec, mepc;
    logic        stall_if, flush_if, flush_id, pc_redirect_en, trap_en;
    logic [31:0] pc_redirect_addr, trap_mepc, trap_mcause;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.RESET_PC(RST_PC), .IRQ_CODE(32'd11)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .instruction_addr_id(instruction_addr_id),
        .reg1_raddr(reg1_raddr), .reg2_raddr(reg2_raddr),
        .exception_raise_id(exception_raise_id), .exception_code_id(exception_code_id),
        .reg_wen_ex(reg_wen_ex), .rd_ex(rd_ex), .ram_load_access_ex(ram_load_access_ex),
        .jump_en_ex(jump_en_ex), .jump_addr_ex(jump_addr_ex),
        .mret_ex(mret_ex), .wfi_ex(wfi_ex), .instruction_addr_ex(instruction_addr_ex),
        .mem_busy(mem_busy), .irq_pending(irq_pending), .mstatus_mie(mstatus_mie),
        .mtvec(mtvec), .mepc(mepc),
        .stall_if(stall_if), .flush_if(flush_if), .flush_id(flush_id),
        .pc_redirect_en(pc_redirect_en), .pc_redirect_addr(pc_redirect_addr),
        .trap_en(trap_en), .trap_mepc(trap_mepc), .trap_mcause(trap_mcause)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; id_valid = 1'b0; instruction_addr_id = '0;
        reg1_raddr = '0; reg2_raddr = '0; exception_raise_id = 1'b0; exception_code_id = '0;
        reg_wen_ex = 1'b0; rd_ex = '0; ram_load_access_ex = 1'b0;
        jump_en_ex = 1'b0; jump_addr_ex = '0; mret_ex = 1'b0; wfi_ex = 1'b0;
        instruction_addr_ex = '0; mem_busy = 1'b0; irq_pending = 1'b0; mstatus_mie = 1'b0;
        mtvec = '0; mepc = '0;
    endtask

    function automatic logic [100:0] dut_vec();
        return {stall_if, flush_if, flush_id, pc_redirect_en, pc_redirect_addr,
                trap_en, trap_mepc, trap_mcause};
    endfunction

    // Reference model: where the core is in the trap/sleep flow, as independent flags.
    bit          m_sleeping, m_draining, m_entering;
    logic [31:0] m_ret_pc, m_cause;

    function automatic logic [100:0] model_out();
        logic s, fi, fd, re, te;
        logic [31:0] ra, tm, tc;
        s = 0; fi = 0; fd = 0; re = 0; te = 0; ra = '0; tm = '0; tc = '0;
        if (rst) begin
            re = 1; ra = RST_PC;
        end else if (m_entering) begin
            te = 1; tm = m_ret_pc; tc = m_cause;
            re = 1; ra = mtvec & 32'hFFFF_FFFC; fi = 1; fd = 1;
        end else if (m_draining) begin
            s = 1; fd = 1;
        end else if (m_sleeping) begin
            s = 1; fd = 1;
            if (irq_pending && !mstatus_mie) begin re = 1; ra = m_ret_pc; fi = 1; end
        end else if (jump_en_ex) begin
            re = 1; ra = jump_addr_ex; fi = 1; fd = 1;
        end else if (mret_ex) begin
            re = 1; ra = mepc; fi = 1; fd = 1;
        end else if (wfi_ex || (id_valid && (exception_raise_id || (irq_pending && mstatus_mie)))) begin
            s = 1; fd = 1;
        end else if (ram_load_access_ex && reg_wen_ex && rd_ex != 0 &&
                     (rd_ex == reg1_raddr || rd_ex == reg2_raddr)) begin
            s = 1; fd = 1;
        end
        return {s, fi, fd, re, ra, te, tm, tc};
    endfunction

    task automatic model_step();
        if (rst) begin
            m_sleeping = 0; m_draining = 0; m_entering = 0; m_ret_pc = '0; m_cause = '0;
        end else if (m_entering) begin
            m_entering = 0;
        end else if (m_draining) begin
            if (!mem_busy) begin m_draining = 0; m_entering = 1; end
        end else if (m_sleeping) begin
            if (irq_pending) begin
                m_sleeping = 0;
                if (mstatus_mie) begin m_cause = IRQ_MC; m_draining = 1; end
            end
        end else if (jump_en_ex || mret_ex) begin
            // redirect only
        end else if (wfi_ex) begin
            m_sleeping = 1; m_ret_pc = instruction_addr_ex + 4;
        end else if (id_valid && exception_raise_id) begin
            m_draining = 1; m_ret_pc = instruction_addr_id; m_cause = 32'(exception_code_id);
        end else if (id_valid && irq_pending && mstatus_mie) begin
            m_draining = 1; m_ret_pc = instruction_addr_id; m_cause = IRQ_MC;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++;
        if (dut_vec() !== {4'b0001, RST_PC, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", dut_vec(), {4'b0001, RST_PC, 1'b0, 64'h0});
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h want 0", dut_vec());
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_valid = 1; ram_load_access_ex = 1; reg_wen_ex = 1; rd_ex = 5'd5; reg1_raddr = 5'd5; reg2_raddr = 5'd7;
        @(negedge clk);
        checks++;
        if ({stall_if, flush_id, flush_if, pc_redirect_en} !== 4'b1100) begin
            errors++;
            $display("FAIL load_use_stall: got %b want 1100", {stall_if, flush_id, flush_if, pc_redirect_en});
        end
        tick();
        // the flush put a bubble into EX; the load has moved on
        ram_load_access_ex = 0; reg_wen_ex = 0; rd_ex = 0;
        @(negedge clk);
        checks++;
        if ({stall_if, flush_id} !== 2'b00) begin
            errors++;
            $display("FAIL load_use_one_cycle: got %b want 00", {stall_if, flush_id});
        end
        tick();
        ram_load_access_ex = 1; reg_wen_ex = 1; rd_ex = 5'd0; reg1_raddr = 5'd0; reg2_raddr = 5'd0;
        @(negedge clk);
        checks++;
        if ({stall_if, flush_id} !== 2'b00) begin
            errors++;
            $display("FAIL load_use_x0: got %b want 00", {stall_if, flush_id});
        end
        tick();
    endtask

    task automatic test_branch_vs_exception();
        clear_inputs();
        jump_en_ex = 1; jump_addr_ex = 32'h100;
        id_valid = 1; exception_raise_id = 1; exception_code_id = 4'd2; instruction_addr_id = 32'h60;
        @(negedge clk);
        checks++;
        if ({pc_redirect_en, pc_redirect_addr, flush_if, flush_id, trap_en} !== {1'b1, 32'h100, 3'b110}) begin
            errors++;
            $display("FAIL branch_redirect: got en=%b addr=%h fi=%b fd=%b te=%b want 1 00000100 1 1 0",
                     pc_redirect_en, pc_redirect_addr, flush_if, flush_id, trap_en);
        end
        tick();
        clear_inputs();
        begin
            int traps = 0;
            for (int unsigned c = 0; c < 10; c++) begin
                @(negedge clk);
                if (trap_en === 1'b1) traps++;
                tick();
            end
            checks++;
            if (traps !== 0) begin
                errors++;
                $display("FAIL branch_no_trap: got %0d trap strobes want 0", traps);
            end
        end
    endtask

    task automatic test_ecall_drain();
        int traps = 0;
        clear_inputs();
        mtvec = 32'h205;
        id_valid = 1; exception_raise_id = 1; exception_code_id = 4'd11; instruction_addr_id = 32'h40;
        for (int unsigned c = 0; c < 8; c++) begin
            if (c != 0) begin
                id_valid = 0; exception_raise_id = 0;
                mem_busy = (c <= 3);
            end
            @(negedge clk);
            if (trap_en === 1'b1) traps++;
            if (c <= 4) begin
                checks++;
                if ({stall_if, flush_id, trap_en} !== 3'b110) begin
                    errors++;
                    $display("FAIL ecall_drain_c%0d: got st=%b fd=%b te=%b want 1 1 0", c, stall_if, flush_id, trap_en);
                end
            end
            if (c == 5) begin
                checks++;
                if ({trap_en, trap_mepc, trap_mcause, pc_redirect_en, pc_redirect_addr, flush_if, flush_id} !==
                    {1'b1, 32'h40, 32'd11, 1'b1, 32'h204, 2'b11}) begin
                    errors++;
                    $display("FAIL ecall_enter: got te=%b mepc=%h mcause=%h en=%b addr=%h fi=%b fd=%b",
                             trap_en, trap_mepc, trap_mcause, pc_redirect_en, pc_redirect_addr, flush_if, flush_id);
                end
            end
            tick();
        end
        checks++;
        if (traps !== 1) begin
            errors++;
            $display("FAIL ecall_trap_count: got %0d want 1", traps);
        end
    endtask

    task automatic test_wfi_irq();
        int bad = 0;
        clear_inputs();
        mstatus_mie = 1; mtvec = 32'h300;
        wfi_ex = 1; instruction_addr_ex = 32'h80;
        tick();
        wfi_ex = 0; instruction_addr_ex = 32'h0;
        for (int unsigned c = 0; c < 10; c++) begin
            @(negedge clk);
            if ({stall_if, flush_id, pc_redirect_en, trap_en} !== 4'b1100) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL wfi_sleep_stall: got %0d bad cycles want 0", bad);
        end
        irq_pending = 1;
        tick();
        irq_pending = 0;
        @(negedge clk);
        checks++;
        if ({stall_if, trap_en} !== 2'b10) begin
            errors++;
            $display("FAIL wfi_irq_drain: got st=%b te=%b want 1 0", stall_if, trap_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({trap_en, trap_mepc, trap_mcause, pc_redirect_addr} !== {1'b1, 32'h84, IRQ_MC, 32'h300}) begin
            errors++;
            $display("FAIL wfi_irq_trap: got te=%b mepc=%h mcause=%h addr=%h want 1 00000084 8000000b 00000300",
                     trap_en, trap_mepc, trap_mcause, pc_redirect_addr);
        end
        tick();
    endtask

    task automatic test_wfi_nomie_mret();
        clear_inputs();
        wfi_ex = 1; instruction_addr_ex = 32'h80;
        tick();
        wfi_ex = 0;
        irq_pending = 1;
        @(negedge clk);
        checks++;
        if ({pc_redirect_en, pc_redirect_addr, flush_if, trap_en} !== {1'b1, 32'h84, 2'b10}) begin
            errors++;
            $display("FAIL wfi_wake_nomie: got en=%b addr=%h fi=%b te=%b want 1 00000084 1 0",
                     pc_redirect_en, pc_redirect_addr, flush_if, trap_en);
        end
        tick();
        irq_pending = 0; mret_ex = 1; mepc = 32'h84;
        @(negedge clk);
        checks++;
        if ({pc_redirect_en, pc_redirect_addr, flush_if, flush_id, stall_if} !== {1'b1, 32'h84, 3'b110}) begin
            errors++;
            $display("FAIL mret_redirect: got en=%b addr=%h fi=%b fd=%b st=%b want 1 00000084 1 1 0",
                     pc_redirect_en, pc_redirect_addr, flush_if, flush_id, stall_if);
        end
        tick();
    endtask

    task automatic test_reset_in_drain();
        int traps = 0;
        clear_inputs();
        id_valid = 1; exception_raise_id = 1; exception_code_id = 4'd3; instruction_addr_id = 32'h44;
        tick();
        id_valid = 0; exception_raise_id = 0; mem_busy = 1;
        tick();
        rst = 1; mem_busy = 0;
        @(negedge clk);
        checks++;
        if ({pc_redirect_en, pc_redirect_addr, trap_en, stall_if} !== {1'b1, RST_PC, 2'b00}) begin
            errors++;
            $display("FAIL rst_in_drain: got en=%b addr=%h te=%b st=%b want 1 %h 0 0",
                     pc_redirect_en, pc_redirect_addr, trap_en, stall_if, RST_PC);
        end
        tick();
        rst = 0;
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge clk);
            if (trap_en === 1'b1 || stall_if === 1'b1) traps++;
            tick();
        end
        checks++;
        if (traps !== 0) begin
            errors++;
            $display("FAIL rst_drain_aborted: got %0d trap/stall cycles want 0", traps);
        end
    endtask

    task automatic test_random();
        logic [100:0] exp_v;
        logic prev_trap = 0;
        clear_inputs();
        rst = 1;
        for (int unsigned n = 0; n < 3000; n++) begin
            if (n != 0) begin
                rst                 = ($urandom_range(0, 63) == 0);
                id_valid            = ($urandom_range(0, 3) != 0);
                instruction_addr_id = $urandom & 32'hFFFF_FFFC;
                reg1_raddr          = 5'($urandom_range(0, 3));
                reg2_raddr          = 5'($urandom_range(0, 3));
                exception_raise_id  = ($urandom_range(0, 7) == 0);
                exception_code_id   = 4'($urandom);
                reg_wen_ex          = ($urandom_range(0, 1) == 0);
                rd_ex               = 5'($urandom_range(0, 3));
                ram_load_access_ex  = ($urandom_range(0, 2) == 0);
                jump_en_ex          = ($urandom_range(0, 7) == 0);
                jump_addr_ex        = $urandom;
                mret_ex             = ($urandom_range(0, 15) == 0);
                wfi_ex              = ($urandom_range(0, 15) == 0);
                instruction_addr_ex = $urandom & 32'hFFFF_FFFC;
                mem_busy            = ($urandom_range(0, 1) == 0);
                irq_pending         = ($urandom_range(0, 5) == 0);
                mstatus_mie         = ($urandom_range(0, 1) == 0);
                mtvec               = $urandom;
                mepc                = $urandom;
            end
            @(negedge clk);
            exp_v = model_out();
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h want %h", n, dut_vec(), exp_v);
            end
            if (prev_trap && trap_en === 1'b1) begin
                errors++;
                $display("FAIL trap_back_to_back_%0d: got trap_en=1 twice want single strobe", n);
            end
            prev_trap = (trap_en === 1'b1);
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch_vs_exception();
        test_ecall_drain();
        test_wfi_irq();
        test_wfi_nomie_mret();
        test_reset_in_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
